// File: rtl/dcache_ctrl_if.sv
// Signal bundle between the MEM stage, the data cache controller and main memory.
// The cache controller uses the slave modport; the pipeline/memory side uses master.
interface dcache_ctrl_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        hit;
    logic [31:0] readData;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  MemRead, MemWrite, address, writeData, mem_ready, mem_rdata,
        output hit, readData, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output MemRead, MemWrite, address, writeData, mem_ready, mem_rdata,
        input  hit, readData, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read hits complete in the same cycle; misses refill a whole line word by word.
module dcache_ctrl #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    dcache_ctrl_if.slave bus
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} state_t;

    state_t           state_q, state_d;
    logic [OFF_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [LINES-1:0] valid_q, valid_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;

    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES][WORDS_PER_LINE];

    logic [TAG_W-1:0] req_tag, lat_tag;
    logic [IDX_W-1:0] req_idx, lat_idx;
    logic [OFF_W-1:0] req_off, lat_off;
    logic             lookup_hit, read_hit, lat_line_hit;
    logic             fill_we, upd_we;

    // The latched memory address doubles as the held request for FILL/WRITE.
    assign req_off = bus.address[OFF_W+1:2];
    assign req_idx = bus.address[IDX_W+OFF_W+1:OFF_W+2];
    assign req_tag = bus.address[31:IDX_W+OFF_W+2];
    assign lat_off = mem_addr_q[OFF_W+1:2];
    assign lat_idx = mem_addr_q[IDX_W+OFF_W+1:OFF_W+2];
    assign lat_tag = mem_addr_q[31:IDX_W+OFF_W+2];
    assign cnt_inc = cnt_q + OFF_W'(1);

    assign lookup_hit   = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign lat_line_hit = valid_q[lat_idx] && (tag_mem[lat_idx] == lat_tag);
    assign read_hit     = (state_q == IDLE) && bus.MemRead && !bus.MemWrite && lookup_hit;

    assign bus.hit      = (state_q == WDONE) || read_hit ||
                          ((state_q == IDLE) && !(bus.MemRead || bus.MemWrite));
    assign bus.readData = read_hit ? data_mem[req_idx][req_off] : 32'h0;

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fill_we     = 1'b0;
        upd_we      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.MemWrite) begin
                    state_d     = WRITE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = bus.address & 32'hFFFF_FFFC;
                    mem_wdata_d = bus.writeData;
                end else if (bus.MemRead && !lookup_hit) begin
                    // Invalidate now so a partially refilled line can never hit.
                    state_d          = FILL;
                    cnt_d            = '0;
                    valid_d[req_idx] = 1'b0;
                    mem_req_d        = 1'b1;
                    mem_we_d         = 1'b0;
                    mem_addr_d       = {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
                end
            end
            FILL: begin
                if (bus.mem_ready) begin
                    fill_we    = 1'b1;
                    cnt_d      = cnt_inc;
                    mem_addr_d = {lat_tag, lat_idx, cnt_inc, 2'b00};
                    if (cnt_q == LAST_WORD) begin
                        valid_d[lat_idx] = 1'b1;
                        mem_req_d        = 1'b0;
                        state_d          = IDLE;
                    end
                end
            end
            WRITE: begin
                if (bus.mem_ready) begin
                    upd_we    = lat_line_hit;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = WDONE;
                end
            end
            WDONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            valid_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Tag and data arrays need no reset: the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[lat_idx][cnt_q] <= bus.mem_rdata;
            tag_mem[lat_idx]         <= lat_tag;
        end else if (upd_we) begin
            data_mem[lat_idx][lat_off] <= mem_wdata_q;
        end
    end
endmodule
